iter_mul_unit: RTL

Parametrised iterative multiplier for the RV32M/RV64M execute stage. It implements MUL, MULH, MULHSU and MULHU with correct signedness, processes BPC multiplier bits per cycle and uses a start/valid handshake. It also provides a pipeline flush. The execute stage stalls on `busy_o` and writes back `result_o` when `valid_o` pulses.

---
 rtl/iter_mul_unit_if.sv | 23 ++
 rtl/iter_mul_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/iter_mul_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
interface iter_mul_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, valid, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, valid, result
  );
endinterface

// File: rtl/iter_mul_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU, BPC multiplier bits per cycle.
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// CALC  | N shift-add steps over the magnitude operands
// FIX   | apply result sign, select product half, pulse valid
module iter_mul_unit #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic          clk,
  input  logic          rst,
  iter_mul_unit_if.slave bus
);
  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        op_q;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [2*XLEN-1:0] prod;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   result_q;
  logic              valid_q;

  logic              accept;
  logic              sa_in;
  logic              sb_in;
  logic [XLEN+BPC-1:0] step_sum;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    accept   = (state == S_IDLE) && bus.start && !bus.flush;
    sa_in    = ((bus.op == OP_MULH) || (bus.op == OP_MULHSU)) && bus.a[XLEN-1];
    sb_in    = (bus.op == OP_MULH) && bus.b[XLEN-1];
    // Upper accumulator plus one partial product; the extra BPC bits hold the carry.
    step_sum = {{BPC{1'b0}}, prod[2*XLEN-1:XLEN]}
             + ({{BPC{1'b0}}, mag_a} * {{XLEN{1'b0}}, prod[BPC-1:0]});
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (bus.start) state_nxt = S_CALC;
        S_CALC:  if (count == LAST) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      prod     <= '0;
      count    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        op_q   <= bus.op;
        sign_a <= sa_in;
        sign_b <= sb_in;
        mag_a  <= sa_in ? -bus.a : bus.a;
        prod   <= {{XLEN{1'b0}}, (sb_in ? -bus.b : bus.b)};
        count  <= '0;
      end else if ((state == S_CALC) && !bus.flush) begin
        prod  <= {step_sum, prod[XLEN-1:BPC]};
        count <= count + CW'(1);
      end else if ((state == S_FIX) && !bus.flush) begin
        result_q <= (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        valid_q  <= 1'b1;
      end
      if (bus.flush) count <= '0;
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
endmodule
